mtr_pwm_drv: RTL
================

# mtr_pwm_drv

Dual-channel motor PWM driver that consumes the signed 12-bit `lft_spd`/`rght_spd` produced by balance control and generates complementary high-side/low-side gate drives for each H-bridge. The block provides a 2048-cycle PWM period, a fixed non-overlap dead time and period-synchronous duty update. It also includes over-current blanking and counting, with latched shutdown. It sits between balance control and the gate-driver pins.

## Interface
- `DEAD`, 32: non-overlap cycles between opposing gate edges; legal range 1..255.
- `BLANK`, 128: cycles after a high-side rising edge during which the over-current input is ignored.
- `OVR_LIMIT`, 3: consecutive faulted periods that trigger shutdown; legal range 1..15.

- `clk`  in  1  system clock (50 MHz).
- `rst`  in  1  reset; one clock, synchronous, active-high.
- `lft_spd`  in  12  signed left motor speed.
- `rght_spd`  in  12  signed right motor speed.
- `drv_en`  in  1  drive enable; low forces all gates off and clears the fault state.
- `lft_ovr`  in  1  left bridge over-current comparator, already synchronized.
- `rght_ovr`  in  1  right bridge over-current comparator, already synchronized.
- `lft_hi`, `lft_lo`  out  1 each  left high-side and low-side gate drives.
- `rght_hi`, `rght_lo`  out  1 each  right high-side and low-side gate drives.
- `pwm_synch`  out  1  one-cycle pulse marking the period boundary.
- `ovr_shtdwn`  out  1  latched over-current shutdown.

## Operation
- Counter `cnt`:
  - 11-bit, increments every clock, wraps from 0x7FF to 0x000.
  - Period is 2048 clocks.
  - `pwm_synch` = (`cnt` == 0x7FF), decoded from the counter register.
- Duty computation, per channel:
  - Saturate the speed to [-1024, +1023]: values above 0x3FF become 0x3FF; values below 0xC00 become 0xC00.
  - duty = saturated speed + 1024, an 11-bit unsigned value (0..2047). Zero speed gives duty 0x400.
- Duty shadow registers:
  - Loaded only on the edge where `cnt` == 0x7FF.
  - The new duty governs from `cnt` = 0 onward.
  - Speed changes mid-period have no effect until the next boundary.
- Gate logic, all outputs registered. Each gate output is the next-state value, delivered at the next edge:
  - hi_next = gate_ok & (`cnt` >= DEAD) & (`cnt` < duty).
  - lo_next = gate_ok & ({1'b0,`cnt`} >= duty + DEAD), using 12-bit compare with no wrap.
  - gate_ok = `drv_en` & ~`ovr_shtdwn`.
  - hi and lo of the same channel are never simultaneously 1.
  - Every hi↔lo transition has ≥ DEAD cycles with both low, including across the period wrap.
- Blanking, per channel:
  - An 8-bit (sized for BLANK) counter clears while hi is 0.
  - It increments while hi is 1 and saturates at BLANK.
  - An over-current sample is valid when hi = 1 and the counter == BLANK.
- Fault accounting:
  - A per-period flag sets on any valid over-current sample on either channel.
  - On the `cnt` == 0x7FF edge:
    - If flag (including a sample in that same cycle) is set: fault_cnt <= fault_cnt + 1, saturating.
    - Otherwise: fault_cnt <= 0.
    - The flag clears.
  - When the incremented fault_cnt equals OVR_LIMIT, `ovr_shtdwn` <= 1 on that same edge.
- Shutdown:
  - `ovr_shtdwn` is sticky.
  - Cleared only by `rst`, or by `drv_en` = 0 (which also clears fault_cnt, the flag and the blanking counters).
  - The counter and duty shadows keep running during shutdown and while disabled.

## Timing
- Reset values:
  - `cnt` = 0; duty shadows = 0x400.
  - All gate outputs = 0; `ovr_shtdwn` = 0; fault_cnt = 0; flag = 0; blanking counters = 0.
  - `pwm_synch` = 0 while `cnt` ≠ 0x7FF.
- `rst` asserted mid-period: all of the above take effect on the next edge; the gates drop immediately on that edge.
- Latency:
  - Gate edges lag the qualifying `cnt` value by 1 clock.
  - A speed input sampled at the 0x7FF edge first affects the gates at the edge after `cnt` = 0.
- `drv_en` falling: gates are 0 one clock later. `drv_en` rising: gating resumes within the current period using the current shadow duty.
- Simultaneous shadow load and fault evaluation on the 0x7FF edge: both occur. Shutdown asserted on that edge blocks the gates from the next edge.
- Duty 2047 (full positive): hi covers `cnt` 32..2046 (2015 cycles); lo never asserts.
- Duty 0 (full negative): hi never asserts; lo covers `cnt` 32..2047 (2016 cycles).

## Test plan
- Reset, then `drv_en` = 1 with both speeds 0: per period, `lft_hi` is high 992 cycles (`cnt` 32..1023) and `lft_lo` is high 992 cycles (`cnt` 1056..2047). Both are never high together, and `pwm_synch` is one pulse every 2048 clocks.
- `lft_spd` = 0x7FF and `rght_spd` = 0x800: `lft_hi` is high 2015 cycles with `lft_lo` = 0. `rght_hi` = 0 with `rght_lo` high 2016 cycles. Also check 0x500 saturates to the same result as 0x3FF.
- Change `lft_spd` from 0 to 0x200 at `cnt` = 500: the current period keeps its 992-cycle hi. The next period has hi for `cnt` 32..1535 (1504 cycles).
- Hold `lft_ovr` = 1 with zero speeds and OVR_LIMIT = 3: `ovr_shtdwn` rises on the third 0x7FF edge and all gates are 0 from the next clock. Pulsing `drv_en` low for 1 clock clears `ovr_shtdwn`.
- Assert `lft_ovr` only during the first 100 cycles after each `lft_hi` rise: no fault is counted and `ovr_shtdwn` stays 0. Faulting in two periods and then one clean period resets fault_cnt.
- Assert `rst` for 1 clock mid-period with `lft_hi` = 1: all outputs are 0 on the next edge, `cnt` restarts at 0, and the duty reverts to 0x400.

Source files
------------

// File: rtl/mtr_pwm_drv.sv
// mtr_pwm_drv: dual H-bridge PWM with dead time, over-current blanking and latched shutdown
module mtr_pwm_drv #(
  parameter int DEAD = 32,
  parameter int BLANK = 128,
  parameter int OVR_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] lft_spd,
  input  logic [11:0] rght_spd,
  input  logic        drv_en,
  input  logic        lft_ovr,
  input  logic        rght_ovr,
  output logic        lft_hi,
  output logic        lft_lo,
  output logic        rght_hi,
  output logic        rght_lo,
  output logic        pwm_synch,
  output logic        ovr_shtdwn
);
  localparam logic [11:0] DT = 12'(DEAD);
  localparam logic [7:0] BLK = 8'(BLANK);
  localparam logic [3:0] LIM = 4'(OVR_LIMIT);
  logic [10:0] cnt, lft_duty, rght_duty;
  logic [7:0] lft_blk, rght_blk;
  logic [3:0] fault_cnt, fault_inc;
  logic flag, wrap, gate_ok, ovr_now, faulted;
  // Saturate to [-1024,1023] then offset by 1024: in range, that is just flipping bit 10
  function automatic logic [10:0] duty_of(input logic [11:0] s);
    return (~s[11] & s[10]) ? 11'h7FF : (s[11] & ~s[10]) ? 11'h000 : {~s[10], s[9:0]};
  endfunction
  assign wrap = cnt == 11'h7FF;
  assign pwm_synch = wrap;
  assign gate_ok = drv_en & ~ovr_shtdwn;
  assign ovr_now = (lft_hi & (lft_blk == BLK) & lft_ovr) | (rght_hi & (rght_blk == BLK) & rght_ovr);
  assign faulted = flag | ovr_now;
  assign fault_inc = (fault_cnt == 4'hF) ? 4'hF : fault_cnt + 4'd1;
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      lft_duty <= 11'h400;
      rght_duty <= 11'h400;
      {lft_hi, lft_lo, rght_hi, rght_lo} <= '0;
      ovr_shtdwn <= 1'b0;
      fault_cnt <= '0;
      flag <= 1'b0;
    end else begin
      cnt <= cnt + 11'd1;
      if (wrap) begin
        lft_duty <= duty_of(lft_spd);
        rght_duty <= duty_of(rght_spd);
      end
      lft_hi <= gate_ok & ({1'b0, cnt} >= DT) & (cnt < lft_duty);
      lft_lo <= gate_ok & ({1'b0, cnt} >= {1'b0, lft_duty} + DT);
      rght_hi <= gate_ok & ({1'b0, cnt} >= DT) & (cnt < rght_duty);
      rght_lo <= gate_ok & ({1'b0, cnt} >= {1'b0, rght_duty} + DT);
      if (!drv_en) begin
        ovr_shtdwn <= 1'b0;
        fault_cnt <= '0;
        flag <= 1'b0;
      end else if (wrap) begin
        fault_cnt <= faulted ? fault_inc : 4'd0;
        flag <= 1'b0;
        if (faulted && fault_inc == LIM) ovr_shtdwn <= 1'b1;
      end else if (ovr_now) begin
        flag <= 1'b1;
      end
    end
  end
  // Blanking counters only run while the high side is on
  always_ff @(posedge clk) begin
    lft_blk <= (rst | ~drv_en | ~lft_hi) ? 8'd0 : (lft_blk == BLK) ? BLK : lft_blk + 8'd1;
    rght_blk <= (rst | ~drv_en | ~rght_hi) ? 8'd0 : (rght_blk == BLK) ? BLK : rght_blk + 8'd1;
  end
endmodule
